// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: turns hazard requests into
// timed bubble sequences, squashes wrong-path work on taken branches, counts events.
module pipeline_stall_ctrl #(
  parameter int RAW_STALL  = 2,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             RawReq,
  input  logic             LoadUseReq,
  input  logic             BranchTaken,
  input  logic             Freeze,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Flush,
  output logic             Stalled,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [1:0] RawCnt  = 2'(RAW_STALL - 1);
  localparam logic [1:0] LoadCnt = 2'(LOAD_STALL - 1);

  state_t     state;
  logic [1:0] cnt;
  logic       doFlush;
  logic       doBubble;

  // The stall counter already covers the hazard, so requests only matter from RUN.
  always_comb begin
    doFlush  = 1'b0;
    doBubble = 1'b0;
    if (Rst_n && !Freeze) begin
      if (BranchTaken)
        doFlush = 1'b1;
      else if (state == STALL || RawReq || LoadUseReq)
        doBubble = 1'b1;
    end
  end

  always_comb begin
    PCWrite      = Rst_n && !Freeze && !doBubble;
    IF_ID_Write  = Rst_n && !Freeze && !doBubble;
    IF_ID_Flush  = doFlush;
    ID_EX_Bubble = doFlush || doBubble;
    EX_MEM_Flush = doFlush;
    Stalled      = doBubble;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= RUN;
      cnt        <= 2'd0;
      StallCount <= '0;
      FlushCount <= '0;
    end else if (!Freeze) begin
      if (BranchTaken) begin
        state <= RUN;
        cnt   <= 2'd0;
        if (FlushCount != '1) FlushCount <= FlushCount + 1'b1;
      end else if (state == STALL) begin
        if (StallCount != '1) StallCount <= StallCount + 1'b1;
        if (cnt == 2'd1) begin
          state <= RUN;
          cnt   <= 2'd0;
        end else begin
          cnt <= cnt - 2'd1;
        end
      end else if (RawReq || LoadUseReq) begin
        // A one-bubble hazard stays in RUN so a held request simply re-stalls.
        if (StallCount != '1) StallCount <= StallCount + 1'b1;
        if (RawReq) begin
          if (RawCnt != 2'd0) begin
            state <= STALL;
            cnt   <= RawCnt;
          end
        end else if (LoadCnt != 2'd0) begin
          state <= STALL;
          cnt   <= LoadCnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: vector table for the main cycle sequence
// plus hand-written reset-mid-stall and counter-saturation sequences.
module tb_pipeline_stall_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n, RawReq, LoadUseReq, BranchTaken, Freeze;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Flush, Stalled;
  logic [15:0] StallCount, FlushCount;
  logic        sPCWrite, sIfIdWrite, sIfIdFlush, sBubble, sExMemFlush, sStalled;
  logic [3:0]  sStallCount, sFlushCount;

  int passCount = 0;
  int checkCount = 0;

  always #5 Clk = ~Clk;

  pipeline_stall_ctrl #(.RAW_STALL(2), .LOAD_STALL(1), .CNT_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .RawReq(RawReq), .LoadUseReq(LoadUseReq),
    .BranchTaken(BranchTaken), .Freeze(Freeze), .PCWrite(PCWrite),
    .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble),
    .EX_MEM_Flush(EX_MEM_Flush), .Stalled(Stalled), .StallCount(StallCount),
    .FlushCount(FlushCount)
  );

  // Narrow-counter copy used only to exercise saturation.
  pipeline_stall_ctrl #(.RAW_STALL(2), .LOAD_STALL(1), .CNT_W(4)) dutSmall (
    .Clk(Clk), .Rst_n(Rst_n), .RawReq(RawReq), .LoadUseReq(LoadUseReq),
    .BranchTaken(BranchTaken), .Freeze(Freeze), .PCWrite(sPCWrite),
    .IF_ID_Write(sIfIdWrite), .IF_ID_Flush(sIfIdFlush), .ID_EX_Bubble(sBubble),
    .EX_MEM_Flush(sExMemFlush), .Stalled(sStalled), .StallCount(sStallCount),
    .FlushCount(sFlushCount)
  );

  typedef struct {
    logic [3:0]  in;
    logic [5:0]  out;
    logic [15:0] sc;
    logic [15:0] fc;
  } vec_t;

  // in  = {Freeze, BranchTaken, RawReq, LoadUseReq}
  // out = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Flush, Stalled}
  localparam logic [3:0] I_IDLE = 4'b0000, I_LU = 4'b0001, I_RAW = 4'b0010,
                         I_BR = 4'b0100, I_BRRAW = 4'b0110, I_FRZ = 4'b1000,
                         I_FRZRAW = 4'b1010;
  localparam logic [5:0] O_RUN = 6'b110000, O_BUB = 6'b000101,
                         O_FLUSH = 6'b111110, O_ZERO = 6'b000000;

  vec_t vecs[31];

  function automatic logic [5:0] outBus();
    return {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Flush, Stalled};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [3:0] in);
    @(negedge Clk);
    {Freeze, BranchTaken, RawReq, LoadUseReq} = in;
    #1;
  endtask

  initial begin
    vecs[0]  = '{I_IDLE,   O_RUN,   16'd0,  16'd0};
    vecs[1]  = '{I_IDLE,   O_RUN,   16'd0,  16'd0};
    vecs[2]  = '{I_IDLE,   O_RUN,   16'd0,  16'd0};
    vecs[3]  = '{I_IDLE,   O_RUN,   16'd0,  16'd0};
    vecs[4]  = '{I_IDLE,   O_RUN,   16'd0,  16'd0};
    vecs[5]  = '{I_RAW,    O_BUB,   16'd0,  16'd0};
    vecs[6]  = '{I_IDLE,   O_BUB,   16'd1,  16'd0};
    vecs[7]  = '{I_IDLE,   O_RUN,   16'd2,  16'd0};
    vecs[8]  = '{I_LU,     O_BUB,   16'd2,  16'd0};
    vecs[9]  = '{I_LU,     O_BUB,   16'd3,  16'd0};
    vecs[10] = '{I_LU,     O_BUB,   16'd4,  16'd0};
    vecs[11] = '{I_IDLE,   O_RUN,   16'd5,  16'd0};
    vecs[12] = '{I_RAW,    O_BUB,   16'd5,  16'd0};
    vecs[13] = '{I_BR,     O_FLUSH, 16'd6,  16'd0};
    vecs[14] = '{I_IDLE,   O_RUN,   16'd6,  16'd1};
    vecs[15] = '{I_BRRAW,  O_FLUSH, 16'd6,  16'd1};
    vecs[16] = '{I_IDLE,   O_RUN,   16'd6,  16'd2};
    vecs[17] = '{I_RAW,    O_BUB,   16'd6,  16'd2};
    vecs[18] = '{I_FRZ,    O_ZERO,  16'd7,  16'd2};
    vecs[19] = '{I_FRZ,    O_ZERO,  16'd7,  16'd2};
    vecs[20] = '{I_FRZRAW, O_ZERO,  16'd7,  16'd2};
    vecs[21] = '{I_FRZ,    O_ZERO,  16'd7,  16'd2};
    vecs[22] = '{I_IDLE,   O_BUB,   16'd7,  16'd2};
    vecs[23] = '{I_IDLE,   O_RUN,   16'd8,  16'd2};
    vecs[24] = '{I_RAW,    O_BUB,   16'd8,  16'd2};
    vecs[25] = '{I_RAW,    O_BUB,   16'd9,  16'd2};
    vecs[26] = '{I_RAW,    O_BUB,   16'd10, 16'd2};
    vecs[27] = '{I_IDLE,   O_BUB,   16'd11, 16'd2};
    vecs[28] = '{I_IDLE,   O_RUN,   16'd12, 16'd2};
    vecs[29] = '{I_FRZRAW, O_ZERO,  16'd12, 16'd2};
    vecs[30] = '{I_IDLE,   O_RUN,   16'd12, 16'd2};

    Rst_n = 1'b0;
    {Freeze, BranchTaken, RawReq, LoadUseReq} = I_IDLE;
    repeat (2) @(negedge Clk);
    #1;
    checkOutput("resetOutputs", 16'(outBus()), 16'(O_ZERO));
    checkOutput("resetStallCount", StallCount, 16'd0);
    checkOutput("resetFlushCount", FlushCount, 16'd0);
    Rst_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      applyStimulus(vecs[i].in);
      checkOutput($sformatf("vec%0d.outputs", i), 16'(outBus()), 16'(vecs[i].out));
      checkOutput($sformatf("vec%0d.stallCount", i), StallCount, vecs[i].sc);
      checkOutput($sformatf("vec%0d.flushCount", i), FlushCount, vecs[i].fc);
    end

    // Reset asserted while in STALL: outputs drop at once, then plain RUN.
    applyStimulus(I_RAW);
    applyStimulus(I_IDLE);
    checkOutput("preResetStall", 16'(outBus()), 16'(O_BUB));
    Rst_n = 1'b0;
    #1;
    checkOutput("midStallResetOutputs", 16'(outBus()), 16'(O_ZERO));
    checkOutput("midStallResetCount", StallCount, 16'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    checkOutput("postResetRun0", 16'(outBus()), 16'(O_RUN));
    applyStimulus(I_IDLE);
    checkOutput("postResetRun1", 16'(outBus()), 16'(O_RUN));
    checkOutput("postResetStallCount", StallCount, 16'd0);

    // Saturation on the 4-bit instance: 14 load-use bubbles, then 3 more.
    for (int i = 0; i < 14; i++) applyStimulus(I_LU);
    applyStimulus(I_IDLE);
    checkOutput("satPreload", 16'(sStallCount), 16'd14);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(I_LU);
      checkOutput($sformatf("satBubble%0d", i), 16'(sStalled), 16'd1);
    end
    applyStimulus(I_IDLE);
    checkOutput("satStallCount", 16'(sStallCount), 16'd15);
    checkOutput("wideStallCount", StallCount, 16'd17);
    checkOutput("satFlushCount", 16'(sFlushCount), 16'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumes the hazard-detection requests (RAW, load-use) and the branch resolution from EX/MEM.
- Drives the pipeline-register enables, flushes and bubble insertion for the 5-stage MIPS datapath.
- Turns a single-cycle hazard request into a timed multi-cycle stall (PC and IF/ID held, NOP injected into ID/EX), and squashes wrong-path instructions on a taken branch.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- RAW_STALL, 2, bubbles inserted for an ALU RAW hazard (no forwarding path); legal range 1..3.
- LOAD_STALL, 1, bubbles inserted for a load-use hazard; legal range 1..3.
- CNT_W, 16, width of the performance counters.

Ports:
- Clk  input  1  pipeline clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- RawReq  input  1  ALU RAW hazard detected between ID/EX or EX/MEM destination and IF/ID source (level, sampled every cycle).
- LoadUseReq  input  1  load-use hazard detected (ID_EX_MemRead with matching register).
- BranchTaken  input  1  branch resolved taken in EX/MEM; PC mux selects the target this cycle.
- Freeze  input  1  global hold (debug/single-step): no state advances.
- PCWrite  output  1  PC register enable.
- IF_ID_Write  output  1  IF/ID register enable.
- IF_ID_Flush  output  1  clear IF/ID to NOP at next edge.
- ID_EX_Bubble  output  1  force ID/EX control signals to zero (NOP) at next edge.
- EX_MEM_Flush  output  1  clear EX/MEM control signals at next edge.
- Stalled  output  1  high in every cycle in which a stall bubble is being inserted.
- StallCount  output  CNT_W  number of bubble cycles inserted since reset, saturating at all-ones.
- FlushCount  output  CNT_W  number of taken-branch flushes since reset, saturating at all-ones.

Behaviour:
- State machine: RUN and STALL, plus a 2-bit down-counter `cnt`.
- Reset (Rst_n=0, asynchronous): state=RUN, cnt=0, StallCount=0, FlushCount=0.
  - Outputs are forced while Rst_n=0: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Bubble=0, EX_MEM_Flush=0, Stalled=0.
  - Reset mid-stall abandons the stall immediately.
- Outputs are combinational from state and inputs; all effects apply at the next rising edge (zero-cycle response to a request).
- Request priority: Freeze > BranchTaken > RawReq > LoadUseReq.
- Freeze=1, any state:
  - PCWrite=0, IF_ID_Write=0; all flush, bubble and Stalled outputs 0.
  - state, cnt and counters hold.
- RUN, no request: PCWrite=1, IF_ID_Write=1, all flush/bubble outputs 0, Stalled=0.
- RUN with BranchTaken:
  - PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1, EX_MEM_Flush=1, Stalled=0.
  - FlushCount+1; stays in RUN. Single cycle; any simultaneous RawReq/LoadUseReq is discarded.
- RUN with RawReq (or LoadUseReq): bubble cycle, N=RAW_STALL (or LOAD_STALL).
  - PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, Stalled=1, StallCount+1.
  - If N=1: stay in RUN, and a still-asserted request re-stalls next cycle.
  - If N>1: cnt<=N-1, go to STALL.
- STALL:
  - Same bubble outputs as the RUN bubble cycle; StallCount+1 each cycle.
  - cnt decrements each cycle; when cnt=1 the next state is RUN with cnt=0.
  - RawReq/LoadUseReq are ignored in STALL, because the counter covers the hazard.
- STALL with BranchTaken: the branch wins.
  - Flush outputs as in RUN, PCWrite=1, IF_ID_Write=1, Stalled=0.
  - FlushCount+1, cnt<=0, go to RUN.
- Total bubbles per isolated request = N exactly, with PC held for N cycles.
- Counters saturate: when at all-ones, an increment leaves the value unchanged (no wrap).
- IF_ID_Flush and IF_ID_Write are never both meaningful alone; the IF/ID register gives Flush priority over Write.

Test Plan:
- Reset then idle 5 cycles → PCWrite=1, IF_ID_Write=1 every cycle, all flush outputs 0, StallCount=0.
- RawReq pulse for 1 cycle, RAW_STALL=2 → Stalled=1 and PCWrite=0 for exactly 2 consecutive cycles, then PCWrite=1; StallCount=2.
- LoadUseReq held high for 3 cycles, LOAD_STALL=1 → 3 bubble cycles, StallCount=3, state never leaves RUN.
- RawReq, then BranchTaken in the 2nd stall cycle → that cycle shows IF_ID_Flush=ID_EX_Bubble=EX_MEM_Flush=1 with PCWrite=1; next cycle is normal RUN; StallCount=1, FlushCount=1.
- BranchTaken and RawReq asserted together in RUN → flush only, Stalled=0, StallCount unchanged.
- Freeze=1 during STALL for 4 cycles → all enables 0, cnt holds, and the stall resumes with its remaining cycle after Freeze drops.
- Rst_n asserted mid-stall → outputs go to reset values immediately; first cycle after release is normal RUN.
- Preload StallCount near saturation (CNT_W=4, 14 stalls) then 3 more → StallCount saturates at 15.
